// File: rtl/fetch_queue_if.sv
// Handshake bundle between fetch_queue, the instruction memory port and the IF/ID register.
// The master modport is the fetch_queue side; the slave modport is its environment.
interface fetch_queue_if #(
  parameter int PTR_WIDTH = 2
);
  logic                 req_valid;
  logic                 req_ready;
  logic [63:0]          req_addr;
  logic                 rsp_valid;
  logic [31:0]          rsp_inst;
  logic                 out_valid;
  logic                 out_ready;
  logic [63:0]          out_pc;
  logic [31:0]          out_inst;
  logic                 redirect_valid;
  logic [63:0]          redirect_pc;
  logic [PTR_WIDTH:0]   occupancy;

  modport master (
    output req_valid, req_addr, out_valid, out_pc, out_inst, occupancy,
    input  req_ready, rsp_valid, rsp_inst, out_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  req_valid, req_addr, out_valid, out_pc, out_inst, occupancy,
    output req_ready, rsp_valid, rsp_inst, out_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// Decoupled instruction fetch front end: sequential fetch, credit-limited issue, {pc,inst} FIFO, redirect flush.
// Optional FETCHQ_BYPASS_EN forwards a response straight to IF/ID when the FIFO is empty.
module fetch_queue #(
  parameter int          DEPTH     = 4,
  parameter int          PTR_WIDTH = 2,
  parameter logic [63:0] RESET_PC  = 64'h0
) (
  input logic           clk,
  input logic           reset,
  fetch_queue_if.master bus
);
  localparam int CW = PTR_WIDTH + 1;
  typedef logic [CW-1:0] cnt_t;

  logic [63:0]          pc_mem   [DEPTH];
  logic [31:0]          inst_mem [DEPTH];
  cnt_t                 wptr;
  cnt_t                 rptr;
  cnt_t                 outstanding;
  cnt_t                 drop;
  logic [63:0]          fetch_pc;
  logic [63:0]          rsp_pc;

  cnt_t                 occ;
  logic                 fifo_empty;
  logic [PTR_WIDTH-1:0] widx;
  logic [PTR_WIDTH-1:0] ridx;
  logic                 credit_ok;
  logic                 issue;
  logic                 drop_now;
  logic                 bypass_hit;
  logic                 take_bypass;
  logic                 push;
  logic                 pop;
  logic [63:0]          target_pc;

  // Live demand = buffered entries plus requests whose responses will be kept.
  function automatic logic has_credit(input cnt_t occ_in, input cnt_t outs_in, input cnt_t drop_in);
    logic [CW:0] load;
    load = {1'b0, occ_in} + {1'b0, outs_in} - {1'b0, drop_in};
    return load < (CW+1)'(DEPTH);
  endfunction

  assign occ        = wptr - rptr;
  assign fifo_empty = (wptr == rptr);
  assign widx       = wptr[PTR_WIDTH-1:0];
  assign ridx       = rptr[PTR_WIDTH-1:0];
  assign target_pc  = bus.redirect_pc & ~64'h3;

  assign credit_ok  = has_credit(occ, outstanding, drop);
  assign bus.req_valid = ~reset & ~bus.redirect_valid & credit_ok;
  assign bus.req_addr  = fetch_pc;
  assign issue         = bus.req_valid & bus.req_ready;

  assign drop_now = bus.rsp_valid & (drop != '0);

`ifdef FETCHQ_BYPASS_EN
  assign bypass_hit = fifo_empty & (drop == '0) & bus.rsp_valid & ~bus.redirect_valid;
`else
  assign bypass_hit = 1'b0;
`endif

  assign take_bypass = bypass_hit & bus.out_ready;
  assign push        = bus.rsp_valid & ~drop_now & ~bus.redirect_valid & ~take_bypass;
  assign pop         = ~fifo_empty & bus.out_ready & ~bus.redirect_valid;

  // Empty FIFO presents zeros unless a bypassed response is in flight this cycle.
  always_comb begin
    bus.out_valid = ~fifo_empty | bypass_hit;
    bus.out_pc    = 64'h0;
    bus.out_inst  = 32'h0;
    if (!fifo_empty) begin
      bus.out_pc   = pc_mem[ridx];
      bus.out_inst = inst_mem[ridx];
    end else if (bypass_hit) begin
      bus.out_pc   = rsp_pc;
      bus.out_inst = bus.rsp_inst;
    end
  end

  assign bus.occupancy = occ;

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[widx]   <= rsp_pc;
      inst_mem[widx] <= bus.rsp_inst;
    end
  end

  // rsp_pc tracks the PC of the next kept response: kept responses are exactly
  // the sequential requests issued since the last redirect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr        <= '0;
      rptr        <= '0;
      outstanding <= '0;
      drop        <= '0;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
    end else begin
      outstanding <= outstanding + cnt_t'(issue) - cnt_t'(bus.rsp_valid);
      if (bus.redirect_valid) begin
        rptr     <= wptr;
        drop     <= outstanding - cnt_t'(bus.rsp_valid);
        fetch_pc <= target_pc;
        rsp_pc   <= target_pc;
      end else begin
        wptr <= wptr + cnt_t'(push);
        rptr <= rptr + cnt_t'(pop);
        drop <= drop - cnt_t'(drop_now);
        if (issue) fetch_pc <= fetch_pc + 64'd4;
        if (bus.rsp_valid && !drop_now) rsp_pc <= rsp_pc + 64'd4;
      end
    end
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Decoupled instruction-fetch front end for the 5-stage RISC-V pipeline. It sits between a handshaked, fixed-order, variable-latency instruction memory port and the IF/ID pipeline register. It generates sequential fetch addresses, buffers returned instructions in a small FIFO, and presents them to IF/ID with a valid/ready handshake. On a taken-branch redirect from ID it flushes the FIFO and drops any stale in-flight responses.

## Interface
- DEPTH, 4: FIFO entries and the maximum number of outstanding requests (power of two).
- PTR_WIDTH, 2: log2(DEPTH).
- RESET_PC, 64'h0: fetch address after reset.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  output  1  fetch request valid.
- req_ready  input  1  imem accepts the request.
- req_addr  output  64  byte address of the request (bits [1:0] always 0).
- rsp_valid  input  1  imem returns an instruction, in request order; no backpressure.
- rsp_inst  input  32  returned instruction.
- out_valid  output  1  head entry valid toward IF/ID.
- out_ready  input  1  IF/ID consumes the head (driven as ~if_stall).
- out_pc  output  64  PC of the head entry; 0 when empty.
- out_inst  output  32  instruction of the head entry; 0 when empty.
- redirect_valid  input  1  taken branch resolved in ID.
- redirect_pc  input  64  branch target.
- occupancy  output  PTR_WIDTH+1  valid FIFO entries (debug and verification).

## Operation
- State:
  - fetch_pc (64b)
  - FIFO of {pc, inst} with read and write pointers of PTR_WIDTH+1 bits (the MSB distinguishes wrap)
  - outstanding counter (PTR_WIDTH+1 bits)
  - drop counter (PTR_WIDTH+1 bits)
  - pc_tag FIFO: the PC of each outstanding request, or an equivalent scheme that pairs each response with its PC
- Issue:
  - req_valid = ~redirect_valid && (occupancy + outstanding − drop < DEPTH). Credits therefore guarantee that a response always has a free slot.
  - req_addr = fetch_pc.
  - On a req_valid && req_ready handshake: fetch_pc += 4 (64-bit wrap) and outstanding increments.
- Response:
  - Each response decrements outstanding.
  - If drop > 0, the response is discarded and drop decrements.
  - Otherwise {its pc, rsp_inst} is pushed.
- Pop: out_valid && out_ready advances the read pointer.
- Push and pop in the same cycle are legal at any occupancy, including full and empty.
- Redirect (redirect_valid = 1 at the clock edge):
  - The FIFO empties: read pointer = write pointer.
  - fetch_pc = redirect_pc.
  - drop = outstanding after counting this cycle's response, excluding any response that was itself dropped this cycle.
  - Any pop or push in the redirect cycle is discarded; IF/ID is being flushed anyway.
- Redirect while drop > 0: drop accumulates to the total number of outstanding responses still owed.
- Reset values:
  - req_valid = 1 after reset deassertion; it is 0 only while reset is high.
  - fetch_pc = RESET_PC.
  - Pointers, outstanding, drop, occupancy, out_valid, out_pc and out_inst all 0.
- Reset asserted mid-operation clears all state immediately. Responses that arrive after reset for requests issued before it are a system-level error and are not handled.

## Timing
- Request to IF/ID:
  - Request accepted at edge N, response in cycle M ≥ N+1.
  - The entry is written at edge M; out_valid is high in cycle M+1.
- Sustained throughput is 1 instruction/cycle when imem latency ≤ DEPTH−1 cycles and out_ready stays high.
- Redirect sampled at edge R:
  - First request to redirect_pc in cycle R+1.
  - The first valid output from the new path follows the normal latency.
- out_valid, out_pc and out_inst are registered/FIFO outputs and do not depend combinationally on inputs (except with FETCHQ_BYPASS_EN).

## Configuration
- FETCHQ_BYPASS_EN defined:
  - When the FIFO is empty, drop = 0, rsp_valid = 1 and redirect_valid = 0, the response drives out_valid, out_pc and out_inst combinationally in cycle M.
  - If out_ready = 1, the response is consumed without being written to the FIFO.
  - If out_ready = 0, the response is written to the FIFO as normal.
  - Latency drops to 0 cycles beyond imem.
- Not defined: all outputs come from the FIFO only, with the 1-cycle latency above.

## Test plan
- Reset, imem latency 1, out_ready = 1:
  - Requests go to 0x0, 0x4, 0x8, … on consecutive cycles.
  - After the initial latency, out_pc is 0x0, 0x4, 0x8, … with out_valid high every cycle.
  - occupancy ≤ 1.
- Stall fill: out_ready = 0 for 10 cycles.
  - occupancy saturates at 4.
  - req_valid = 0 once occupancy + outstanding = 4.
  - Releasing out_ready drains 0x0–0xC in order with no loss or duplication.
- Redirect with 3 requests outstanding (latency 3), redirect_pc = 0x100:
  - The three stale responses are dropped.
  - The next out_valid entry has out_pc = 0x100.
  - occupancy = 0 in the cycle after the redirect.
- Back-to-back redirects to 0x200 then 0x300 on consecutive cycles, with drop still nonzero:
  - All stale responses are dropped.
  - The first output has out_pc = 0x300.
- req_ready toggling randomly and out_ready random, 1000 cycles:
  - The output PC stream is strictly +4 between redirects.
  - out_inst matches the memory model.
  - occupancy never exceeds 4.
- Reset asserted while full with 2 responses outstanding: all outputs return to 0 asynchronously, without waiting for a clock edge.
